// File: rtl/log_unit.sv
// Sequential fixed-point logarithm: normalises x to 2^e * m, then extracts
// log2 fraction bits by repeated squaring and optionally scales by ln(2).
module log_unit #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [2:0]       dbg_state_o
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam longint LN2_INT = longint'(0.6931471805599453 * real'(longint'(1) << FRAC));
    localparam logic [WIDTH-1:0] LN2 = WIDTH'(LN2_INT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_ITER  = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  e_q, e_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [ITER-1:0]   frac_q, frac_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_err_q, out_err_d;

    logic [PW-1:0]     msb_pos;
    logic [WIDTH-1:0]  sq;
    logic [WIDTH-1:0]  l_val;
    logic [WIDTH-1:0]  ln_val;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, no overlap.
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_data    = out_data_q;
    assign out_err     = out_err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x_q[i]) msb_pos = i[PW-1:0];
        end
    end

    // m is Q1.(WIDTH-1); its square truncated to Q2.(WIDTH-2) is the top half.
    assign sq     = WIDTH'(({{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, m_q}) >> WIDTH);
    assign l_val  = (e_q << FRAC) + (WIDTH'(frac_q) << (FRAC - ITER));
    assign ln_val = WIDTH'(($signed({{WIDTH{l_val[WIDTH-1]}}, l_val})
                            * $signed({{WIDTH{1'b0}}, LN2})) >>> FRAC);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        mode_d     = mode_q;
        e_d        = e_q;
        m_d        = m_q;
        frac_d     = frac_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d    = in_data;
                    mode_d = mode;
                    if ($signed(in_data) <= 0) begin
                        out_err_d  = 1'b1;
                        out_data_d = {1'b1, {(WIDTH-1){1'b0}}};
                        state_d    = S_DONE;
                    end else begin
                        out_err_d = 1'b0;
                        state_d   = S_NORM;
                    end
                end
            end
            S_NORM: begin
                m_d     = x_q << (PW'(WIDTH - 1) - msb_pos);
                e_d     = WIDTH'(msb_pos) - WIDTH'(FRAC);
                frac_d  = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                // Square >= 2 means the next log2 bit is 1; halving a Q2 value
                // is just reinterpreting the same bits as Q1.
                if (sq[WIDTH-1]) begin
                    m_d    = sq;
                    frac_d = (frac_q << 1) | ITER'(1);
                end else begin
                    m_d    = sq << 1;
                    frac_d = frac_q << 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = S_SCALE;
            end
            S_SCALE: begin
                out_data_d = mode_q ? l_val : ln_val;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            mode_q     <= 1'b0;
            e_q        <= '0;
            m_q        <= '0;
            frac_q     <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            mode_q     <= mode_d;
            e_q        <= e_d;
            m_q        <= m_d;
            frac_q     <= frac_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_log_unit.sv
// Directed-vector bench for log_unit (WIDTH=32, FRAC=16, ITER=16).
module tb_log_unit;

    localparam int W = 32;
    localparam int LAT_POS = 18;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] x;
        logic        m;
        logic [31:0] exp_data;
        logic        exp_err;
        int          tol;
    } vec_t;

    vec_t vecs[$];

    log_unit #(.WIDTH(32), .FRAC(16), .ITER(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        longint d;
        d = longint'($signed(obs)) - longint'($signed(exp));
        if (d < 0) d = -d;
        n_checks++;
        if (d <= longint'(tol)) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", tag, obs, exp, tol);
    endtask

    // Presents one operand, then waits (bounded) for out_valid; lat counts edges after accept.
    task automatic run_op(input logic [31:0] x, input logic m,
                          output logic [31:0] res, output logic err, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = x;
        mode     = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        mode     = ~m;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_data;
        err = out_err;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        err;
        int          lat;
        int          spurious;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1, 0);
        check("rst_out_valid", 32'(out_valid), 32'd0, 0);
        check("rst_out_data", out_data, 32'h0, 0);
        check("rst_out_err", 32'(out_err), 32'd0, 0);
        reset = 1'b1;

        vecs.push_back('{32'h0001_0000, 1'b0, 32'h0000_0000, 1'b0, 0});
        vecs.push_back('{32'h0002_0000, 1'b1, 32'h0001_0000, 1'b0, 0});
        vecs.push_back('{32'h0002_0000, 1'b0, 32'h0000_B172, 1'b0, 0});
        vecs.push_back('{32'h0000_8000, 1'b1, 32'hFFFF_0000, 1'b0, 0});
        vecs.push_back('{32'h0000_8000, 1'b0, 32'hFFFF_4E8E, 1'b0, 0});
        vecs.push_back('{32'h0000_0001, 1'b1, 32'hFFF0_0000, 1'b0, 0});
        vecs.push_back('{32'h4000_0000, 1'b1, 32'h000E_0000, 1'b0, 0});
        vecs.push_back('{32'h7FFF_0000, 1'b1, 32'h000E_FFFD, 1'b0, 2});
        vecs.push_back('{32'h0003_0000, 1'b1, 32'h0001_95C0, 1'b0, 4});
        vecs.push_back('{32'h0003_0000, 1'b0, 32'h0001_193F, 1'b0, 4});
        vecs.push_back('{32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1, 0});
        vecs.push_back('{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 0});
        vecs.push_back('{32'hFFFF_0000, 1'b1, 32'h8000_0000, 1'b1, 0});

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].m, res, err, lat);
            check($sformatf("v%0d_data", i), res, vecs[i].exp_data, vecs[i].tol);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err), 0);
            check($sformatf("v%0d_lat", i), 32'(lat), vecs[i].exp_err ? 32'd0 : 32'(LAT_POS), 0);
            take_result();
            check($sformatf("v%0d_ready_after", i), 32'(in_ready), 32'd1, 0);
        end

        // Backpressure: result must hold while extra operands are offered and ignored.
        run_op(32'h0002_0000, 1'b1, res, err, lat);
        check("bp_first", res, 32'h0001_0000, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 32'h0004_0000;
            @(posedge clk); #1;
            check($sformatf("bp_data_%0d", i), out_data, 32'h0001_0000, 0);
            check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0, 0);
            check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1, 0);
        end
        in_valid = 1'b0;
        take_result();
        check("bp_ready_after", 32'(in_ready), 32'd1, 0);
        check("bp_valid_after", 32'(out_valid), 32'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_queue", 32'(dbg_state), 32'd0, 0);

        // Reset pulse while iterating.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h0003_0000; mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid_state_iter", 32'(dbg_state), 32'd2, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0, 0);
        check("mid_rst_ready", 32'(in_ready), 32'd1, 0);
        check("mid_rst_data", out_data, 32'h0, 0);
        check("mid_rst_err", 32'(out_err), 32'd0, 0);
        #3;
        reset = 1'b1;
        spurious = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check("mid_rst_no_result", 32'(spurious), 32'd0, 0);
        run_op(32'h0000_8000, 1'b0, res, err, lat);
        check("post_rst_data", res, 32'hFFFF_4E8E, 0);
        check("post_rst_lat", 32'(lat), 32'(LAT_POS), 0);
        take_result();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
